// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
//   state_e : master FSM states
//   STATUS_* : response status codes returned on rsp_status
package wb_cmd_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StBackoff,
    StResp
  } state_e;

  localparam logic [1:0] STATUS_OK              = 2'd0;
  localparam logic [1:0] STATUS_ERR             = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT         = 2'd2;
  localparam logic [1:0] STATUS_RETRY_EXHAUSTED = 2'd3;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Bundle of the command, response and Wishbone signals of wb_cmd_master.
//   cmd_*   : valid/ready command port (we, adr, dat, sel)
//   rsp_*   : valid/ready response port (dat, status)
//   wb_*    : pipelined Wishbone B4 master side; wb_dat_w is write data,
//             wb_dat_r is read data from the slave
// Modports: master (the command master itself), slave (its environment).
interface wb_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_adr;
  logic [DATA_WIDTH-1:0]   cmd_dat;
  logic [DATA_WIDTH/8-1:0] cmd_sel;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_dat;
  logic [1:0]              rsp_status;

  logic                    wb_cyc;
  logic                    wb_stb;
  logic                    wb_we;
  logic [ADDR_WIDTH-1:0]   wb_adr;
  logic [DATA_WIDTH/8-1:0] wb_sel;
  logic [DATA_WIDTH-1:0]   wb_dat_w;
  logic [DATA_WIDTH-1:0]   wb_dat_r;
  logic                    wb_ack;
  logic                    wb_err;
  logic                    wb_rty;
  logic                    wb_stall;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
    input  wb_dat_r, wb_ack, wb_err, wb_rty, wb_stall,
    output cmd_ready, rsp_valid, rsp_dat, rsp_status,
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
    output wb_dat_r, wb_ack, wb_err, wb_rty, wb_stall,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_status,
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w
  );

endinterface

// File: rtl/wb_cmd_timeout.sv
// Bus-cycle timeout counter for wb_cmd_master.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : reload to TIMEOUT-1 (start of a bus attempt)
//   en_i         : count down one step (saturates at zero)
//   expired_o    : high during the TIMEOUT-th active cycle after a reload
module wb_cmd_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with TIMEOUT-1, so zero is reached in the TIMEOUT-th counted cycle.
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding pipelined Wishbone B4 master.
// Takes one command from the cmd port, runs one Wishbone cycle (with retry on
// rty and a cycle timeout) and returns read data and a status on the rsp port.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus_io : command, response and Wishbone signals (master modport)
// Every output comes straight from a flop.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_cmd_master_if.master  bus_io
);

  localparam int unsigned SelW   = DATA_WIDTH / 8;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic [RetryW-1:0]     retry_q, retry_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]            rsp_status_q, rsp_status_d;

  logic tmo_clr, tmo_en, tmo_expired;
  logic term_window;

  wb_cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  // Terminations count in WAIT, or in REQ on the cycle the slave takes stb.
  assign term_window = (state_q == StWait) || ((state_q == StReq) && !bus_io.wb_stall);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    retry_d      = retry_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    tmo_clr      = 1'b0;
    tmo_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          we_d    = bus_io.cmd_we;
          adr_d   = bus_io.cmd_adr;
          dat_d   = bus_io.cmd_dat;
          sel_d   = bus_io.cmd_sel;
          retry_d = '0;
          tmo_clr = 1'b1;
          state_d = StReq;
        end
      end

      StReq, StWait: begin
        tmo_en = 1'b1;
        if ((state_q == StReq) && !bus_io.wb_stall) begin
          state_d = StWait;
        end
        // err > ack > rty; any termination beats a same-cycle timeout.
        if (term_window && bus_io.wb_err) begin
          rsp_status_d = STATUS_ERR;
          rsp_dat_d    = '0;
          state_d      = StResp;
        end else if (term_window && bus_io.wb_ack) begin
          rsp_status_d = STATUS_OK;
          rsp_dat_d    = we_q ? '0 : bus_io.wb_dat_r;
          state_d      = StResp;
        end else if (term_window && bus_io.wb_rty) begin
          if (32'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StBackoff;
          end else begin
            rsp_status_d = STATUS_RETRY_EXHAUSTED;
            rsp_dat_d    = '0;
            state_d      = StResp;
          end
        end else if (tmo_expired) begin
          rsp_status_d = STATUS_TIMEOUT;
          rsp_dat_d    = '0;
          state_d      = StResp;
        end
      end

      StBackoff: begin
        tmo_clr = 1'b1;
        state_d = StReq;
      end

      StResp: begin
        if (bus_io.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they are valid as flops.
  assign cyc_d       = (state_d == StReq) || (state_d == StWait);
  assign stb_d       = (state_d == StReq);
  assign cmd_ready_d = (state_d == StIdle);
  assign rsp_valid_d = (state_d == StResp);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      retry_q      <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= STATUS_OK;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      retry_q      <= retry_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign bus_io.cmd_ready  = cmd_ready_q;
  assign bus_io.rsp_valid  = rsp_valid_q;
  assign bus_io.rsp_dat    = rsp_dat_q;
  assign bus_io.rsp_status = rsp_status_q;
  assign bus_io.wb_cyc     = cyc_q;
  assign bus_io.wb_stb     = stb_q;
  assign bus_io.wb_we      = we_q;
  assign bus_io.wb_adr     = adr_q;
  assign bus_io.wb_sel     = sel_q;
  assign bus_io.wb_dat_w   = dat_q;

endmodule
